// File: rtl/butterfly_pipe_if.sv
// -----------------------------------------------------------------------------
// butterfly_pipe_if
// Bundles the streaming handshake, operand/result buses and the overflow
// status/clear pair of the radix-2 butterfly.
//   slave  modport : used by the butterfly itself
//   master modport : used by whatever drives the butterfly (previous stage / bench)
// Signals:
//   in_valid/in_ready               input pair handshake
//   in_1_r/in_1_i, in_2_r/in_2_i    operands a and b (W-bit two's complement)
//   tw_sel                          twiddle select W8^0..W8^3
//   out_valid/out_ready             output pair handshake
//   out_1_r/out_1_i                 a + b*W8^k
//   out_2_r/out_2_i                 a - b*W8^k
//   ovf/ovf_clr                     sticky overflow flag and its clear
// -----------------------------------------------------------------------------
interface butterfly_pipe_if #(
  parameter int W = 8
);
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_1_r;
  logic signed [W-1:0] in_1_i;
  logic signed [W-1:0] in_2_r;
  logic signed [W-1:0] in_2_i;
  logic [1:0]          tw_sel;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_1_r;
  logic signed [W-1:0] out_1_i;
  logic signed [W-1:0] out_2_r;
  logic signed [W-1:0] out_2_i;
  logic                ovf;
  logic                ovf_clr;

  modport slave (
    input  in_valid, in_1_r, in_1_i, in_2_r, in_2_i, tw_sel, out_ready, ovf_clr,
    output in_ready, out_valid, out_1_r, out_1_i, out_2_r, out_2_i, ovf
  );

  modport master (
    output in_valid, in_1_r, in_1_i, in_2_r, in_2_i, tw_sel, out_ready, ovf_clr,
    input  in_ready, out_valid, out_1_r, out_1_i, out_2_r, out_2_i, ovf
  );
endinterface

// File: rtl/butterfly_pipe.sv
// -----------------------------------------------------------------------------
// butterfly_pipe
// Two-stage pipelined radix-2 butterfly with runtime twiddle W8^0..W8^3.
//   Stage 1 registers a and b' = b*W8^k (rounded, narrowed to W bits).
//   Stage 2 registers a+b' and a-b' (narrowed to W bits).
// Valid/ready flow control with bubble collapsing; sticky overflow flag.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (flushes the pipe, clears ovf)
//   bus  butterfly_pipe_if.slave (handshakes, operands, results, ovf/ovf_clr)
// Parameters:
//   N   data width exponent, W = 2**N (must match the interface W)
//   CF  fractional bits of C = round(2^CF/sqrt(2))
// Build option:
//   BUTTERFLY_SAT_EN  defined -> out-of-range results saturate;
//                     undefined -> results wrap (low W bits kept).
//   ovf is raised identically in both builds.
// -----------------------------------------------------------------------------
module butterfly_pipe #(
  parameter int N  = 3,
  parameter int CF = 8
) (
  input  logic             clk,
  input  logic             rst,
  butterfly_pipe_if.slave  bus
);
  localparam int W  = 32'sd1 <<< N;
  localparam int WS = W + 1;          // sum width
  localparam int PW = W + 1 + CF;     // product width

  // C = round(sqrt(2^(2CF-1))) computed by integer binary search.
  function automatic int calc_c(input int cf);
    longint x, lo, hi, mid;
    x  = 64'sd1 <<< (2 * cf - 1);
    lo = 64'sd0;
    hi = 64'sd1 <<< cf;
    while (lo < hi) begin
      mid = (lo + hi + 64'sd1) >>> 1;
      if (mid * mid <= x) lo = mid;
      else                hi = mid - 64'sd1;
    end
    // round up when (lo + 0.5)^2 <= x
    if (64'sd4 * lo * lo + 64'sd4 * lo + 64'sd1 <= 64'sd4 * x) lo = lo + 64'sd1;
    else                                                     lo = lo;
    return int'(lo);
  endfunction

  localparam logic signed [PW-1:0] C_K   = PW'(calc_c(CF));
  localparam logic signed [PW-1:0] RND_K = PW'(32'sd1 <<< (CF - 1));
  localparam logic signed [PW-1:0] MAX_V = PW'((32'sd1 <<< (W - 1)) - 32'sd1);
  localparam logic signed [PW-1:0] MIN_V = PW'(-(32'sd1 <<< (W - 1)));

  // Narrow to W bits; returns {overflow, value}.
  function automatic logic [W:0] narrow(input logic signed [PW-1:0] x);
    logic [W:0] res;
    if (x > MAX_V) begin
`ifdef BUTTERFLY_SAT_EN
      res = {1'b1, MAX_V[W-1:0]};
`else
      res = {1'b1, x[W-1:0]};
`endif
    end else if (x < MIN_V) begin
`ifdef BUTTERFLY_SAT_EN
      res = {1'b1, MIN_V[W-1:0]};
`else
      res = {1'b1, x[W-1:0]};
`endif
    end else begin
      res = {1'b0, x[W-1:0]};
    end
    return res;
  endfunction

  // rnd(s*C) then narrow; returns {overflow, value}.
  function automatic logic [W:0] rot_scale(input logic signed [WS-1:0] s);
    logic signed [PW-1:0] prod;
    prod = PW'(s) * C_K;
    prod = prod + RND_K;
    prod = prod >>> CF;
    return narrow(prod);
  endfunction

  // Pipeline state
  logic                s1_v, s2_v;
  logic signed [W-1:0] s1_a_r, s1_a_i, s1_b_r, s1_b_i;
  logic signed [W-1:0] o1_r, o1_i, o2_r, o2_i;
  logic                ovf;

  // Handshake
  logic s1_adv, s2_adv, in_xfer, s2_load;
  assign s2_adv  = !s2_v || bus.out_ready;
  assign s1_adv  = !s1_v || s2_adv;
  assign in_xfer = bus.in_valid && s1_adv;
  assign s2_load = s1_v && s2_adv;

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_v;
  assign bus.out_1_r   = o1_r;
  assign bus.out_1_i   = o1_i;
  assign bus.out_2_r   = o2_r;
  assign bus.out_2_i   = o2_i;
  assign bus.ovf       = ovf;

  // Stage-1 rotation b' = b*W8^k
  logic signed [WS-1:0] b_sum, b_dif, b_neg;
  logic [W:0]           rot_r, rot_i;
  logic                 rot_ovf;

  // Rotation datapath for the incoming operand b.
  always_comb begin
    b_sum = WS'(bus.in_2_r) + WS'(bus.in_2_i);
    b_dif = WS'(bus.in_2_i) - WS'(bus.in_2_r);
    b_neg = -WS'(bus.in_2_r) - WS'(bus.in_2_i);
    rot_r = {1'b0, bus.in_2_r};
    rot_i = {1'b0, bus.in_2_i};
    case (bus.tw_sel)
      2'd0: begin
        rot_r = {1'b0, bus.in_2_r};
        rot_i = {1'b0, bus.in_2_i};
      end
      2'd1: begin
        rot_r = rot_scale(b_sum);
        rot_i = rot_scale(b_dif);
      end
      2'd2: begin
        // -(-2^(W-1)) does not fit and is flagged by narrow()
        rot_r = {1'b0, bus.in_2_i};
        rot_i = narrow(-PW'(bus.in_2_r));
      end
      2'd3: begin
        rot_r = rot_scale(b_dif);
        rot_i = rot_scale(b_neg);
      end
      default: begin
        rot_r = {1'b0, bus.in_2_r};
        rot_i = {1'b0, bus.in_2_i};
      end
    endcase
    rot_ovf = rot_r[W] || rot_i[W];
  end

  // Stage-2 add/sub
  logic signed [WS-1:0] add_r, add_i, sub_r, sub_i;
  logic [W:0]           n1_r, n1_i, n2_r, n2_i;
  logic                 add_ovf;

  // Butterfly add/sub on the stage-1 registers.
  always_comb begin
    add_r   = WS'(s1_a_r) + WS'(s1_b_r);
    add_i   = WS'(s1_a_i) + WS'(s1_b_i);
    sub_r   = WS'(s1_a_r) - WS'(s1_b_r);
    sub_i   = WS'(s1_a_i) - WS'(s1_b_i);
    n1_r    = narrow(PW'(add_r));
    n1_i    = narrow(PW'(add_i));
    n2_r    = narrow(PW'(sub_r));
    n2_i    = narrow(PW'(sub_i));
    add_ovf = n1_r[W] || n1_i[W] || n2_r[W] || n2_i[W];
  end

  // Pipeline registers and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s2_v   <= 1'b0;
      s1_a_r <= '0;
      s1_a_i <= '0;
      s1_b_r <= '0;
      s1_b_i <= '0;
      o1_r   <= '0;
      o1_i   <= '0;
      o2_r   <= '0;
      o2_i   <= '0;
      ovf    <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_v <= bus.in_valid;
        if (in_xfer) begin
          s1_a_r <= bus.in_1_r;
          s1_a_i <= bus.in_1_i;
          s1_b_r <= rot_r[W-1:0];
          s1_b_i <= rot_i[W-1:0];
        end
      end
      if (s2_adv) begin
        s2_v <= s1_v;
        if (s2_load) begin
          o1_r <= n1_r[W-1:0];
          o1_i <= n1_i[W-1:0];
          o2_r <= n2_r[W-1:0];
          o2_i <= n2_i[W-1:0];
        end
      end
      // a new overflow wins over a simultaneous clear
      if ((in_xfer && rot_ovf) || (s2_load && add_ovf)) ovf <= 1'b1;
      else if (bus.ovf_clr)                             ovf <= 1'b0;
    end
  end
endmodule

// File: tb/tb_butterfly_pipe.sv
// -----------------------------------------------------------------------------
// tb_butterfly_pipe
// Directed self-checking bench for butterfly_pipe (N=3 -> W=8, CF=8).
// Inputs are driven 1 time unit after the rising edge, outputs are sampled
// there as well, away from the active edge.
// -----------------------------------------------------------------------------
module tb_butterfly_pipe;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  butterfly_pipe_if #(.W(8)) bus ();

  butterfly_pipe #(.N(3), .CF(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Stream vectors: a, b, twiddle and hand-computed {out_1_r,out_1_i,out_2_r,out_2_i}
  logic signed [7:0] st_ar [6] = '{8'sd1, 8'sd5, 8'sd10, -8'sd5, 8'sd20, 8'sd0};
  logic signed [7:0] st_ai [6] = '{8'sd2, 8'sd6, 8'sd0,  8'sd5, -8'sd20, 8'sd0};
  logic signed [7:0] st_br [6] = '{8'sd3, 8'sd1, 8'sd2,  8'sd5, 8'sd4, 8'sd100};
  logic signed [7:0] st_bi [6] = '{8'sd4, 8'sd1, 8'sd3,  8'sd5, 8'sd8, 8'sd0};
  logic [1:0]        st_k  [6] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd1};
  logic [31:0]       st_exp[6] = '{
    {8'sd4,  8'sd6,   -8'sd2,  -8'sd2},
    {8'sd6,  8'sd7,   8'sd4,   8'sd5},
    {8'sd13, -8'sd2,  8'sd7,   8'sd2},
    {8'sd0,  8'sd10,  -8'sd10, 8'sd0},
    {8'sd28, -8'sd24, 8'sd12,  -8'sd16},
    {8'sd71, -8'sd71, -8'sd71, 8'sd71}
  };

  function automatic logic [31:0] outs();
    return {bus.out_1_r, bus.out_1_i, bus.out_2_r, bus.out_2_i};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one pair for one cycle (pipe is expected to accept it).
  task automatic send_pair(input logic signed [7:0] ar, ai, br, bi, input logic [1:0] k);
    bus.in_1_r   = ar;
    bus.in_1_i   = ai;
    bus.in_2_r   = br;
    bus.in_2_i   = bi;
    bus.tw_sel   = k;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.tw_sel   = 2'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); n_fail++;
    end
    n_checks++;
    if (outs() !== 32'h0) begin
      $display("FAIL reset_outs got %h exp 00000000", outs()); n_fail++;
    end
    n_checks++;
    if (bus.ovf !== 1'b0) begin
      $display("FAIL reset_ovf got %b exp 0", bus.ovf); n_fail++;
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); n_fail++;
    end
  endtask

  task automatic test_twiddle0();
    send_pair(8'sd10, 8'sd20, 8'sd3, 8'sd4, 2'd0);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL tw0_early_valid got %b exp 0", bus.out_valid); n_fail++;
    end
    step();
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      $display("FAIL tw0_valid got %b exp 1", bus.out_valid); n_fail++;
    end
    n_checks++;
    if (outs() !== {8'sd13, 8'sd24, 8'sd7, 8'sd16}) begin
      $display("FAIL tw0_outs got %h exp %h", outs(), {8'sd13, 8'sd24, 8'sd7, 8'sd16}); n_fail++;
    end
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL tw0_one_cycle got %b exp 0", bus.out_valid); n_fail++;
    end
  endtask

  task automatic test_twiddle2();
    send_pair(8'sd10, 8'sd20, 8'sd3, 8'sd4, 2'd2);
    step();
    n_checks++;
    if (bus.out_valid !== 1'b1 || outs() !== {8'sd14, 8'sd17, 8'sd6, 8'sd23}) begin
      $display("FAIL tw2_outs got v=%b %h exp v=1 %h", bus.out_valid, outs(),
               {8'sd14, 8'sd17, 8'sd6, 8'sd23}); n_fail++;
    end
    step();
  endtask

  task automatic test_twiddle13();
    send_pair(8'sd0, 8'sd0, 8'sd100, 8'sd0, 2'd1);
    step();
    n_checks++;
    if (bus.out_valid !== 1'b1 || outs() !== {8'sd71, -8'sd71, -8'sd71, 8'sd71}) begin
      $display("FAIL tw1_outs got v=%b %h exp v=1 %h", bus.out_valid, outs(),
               {8'sd71, -8'sd71, -8'sd71, 8'sd71}); n_fail++;
    end
    step();
    send_pair(8'sd0, 8'sd0, 8'sd100, 8'sd0, 2'd3);
    step();
    n_checks++;
    if (bus.out_valid !== 1'b1 || outs() !== {-8'sd71, -8'sd71, 8'sd71, 8'sd71}) begin
      $display("FAIL tw3_outs got v=%b %h exp v=1 %h", bus.out_valid, outs(),
               {-8'sd71, -8'sd71, 8'sd71, 8'sd71}); n_fail++;
    end
    n_checks++;
    if (bus.ovf !== 1'b0) begin
      $display("FAIL tw13_no_ovf got %b exp 0", bus.ovf); n_fail++;
    end
    step();
  endtask

  task automatic test_overflow();
    logic [31:0] exp_add, exp_neg;
`ifdef BUTTERFLY_SAT_EN
    exp_add = {8'sd127, 8'sd0, 8'sd0, 8'sd0};
    exp_neg = {8'sd0, 8'sd127, 8'sd0, -8'sd127};
`else
    exp_add = {-8'sd2, 8'sd0, 8'sd0, 8'sd0};       // 254 keeps low byte 0xFE
    exp_neg = {8'sd0, -8'sd128, 8'sd0, -8'sd128};
`endif
    send_pair(8'sd127, 8'sd0, 8'sd127, 8'sd0, 2'd0);
    n_checks++;
    if (bus.ovf !== 1'b0) begin
      $display("FAIL ovf_stage1_clean got %b exp 0", bus.ovf); n_fail++;
    end
    step();
    n_checks++;
    if (outs() !== exp_add) begin
      $display("FAIL ovf_add_outs got %h exp %h", outs(), exp_add); n_fail++;
    end
    n_checks++;
    if (bus.ovf !== 1'b1) begin
      $display("FAIL ovf_set got %b exp 1", bus.ovf); n_fail++;
    end
    step();
    step();
    n_checks++;
    if (bus.ovf !== 1'b1) begin
      $display("FAIL ovf_sticky got %b exp 1", bus.ovf); n_fail++;
    end
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    n_checks++;
    if (bus.ovf !== 1'b0) begin
      $display("FAIL ovf_clr got %b exp 0", bus.ovf); n_fail++;
    end
    // negating -128 for k=2 overflows in stage 1, concurrently with a clear
    bus.ovf_clr = 1'b1;
    send_pair(8'sd0, 8'sd0, -8'sd128, 8'sd0, 2'd2);
    bus.ovf_clr = 1'b0;
    n_checks++;
    if (bus.ovf !== 1'b1) begin
      $display("FAIL ovf_set_beats_clr got %b exp 1", bus.ovf); n_fail++;
    end
    step();
    n_checks++;
    if (outs() !== exp_neg) begin
      $display("FAIL ovf_neg_outs got %h exp %h", outs(), exp_neg); n_fail++;
    end
    step();
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    n_checks++;
    if (bus.ovf !== 1'b0) begin
      $display("FAIL ovf_clr2 got %b exp 0", bus.ovf); n_fail++;
    end
  endtask

  task automatic test_back_to_back_stall();
    int          in_idx = 0;
    int          out_idx = 0;
    logic        holding = 1'b0;
    logic        acc_in;
    logic [31:0] held = 32'h0;
    logic [31:0] got;
    for (int cyc = 0; cyc < 24; cyc++) begin
      bus.out_ready = !(cyc >= 3 && cyc <= 5);
      if (in_idx < 6) begin
        bus.in_1_r   = st_ar[in_idx];
        bus.in_1_i   = st_ai[in_idx];
        bus.in_2_r   = st_br[in_idx];
        bus.in_2_i   = st_bi[in_idx];
        bus.tw_sel   = st_k[in_idx];
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      got = outs();
      if (holding) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || got !== held) begin
          $display("FAIL stall_hold cyc %0d got v=%b %h exp v=1 %h", cyc, bus.out_valid, got, held);
          n_fail++;
        end
      end
      if (cyc == 2) begin
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
          $display("FAIL stall_ready_pre got %b exp 1", bus.in_ready); n_fail++;
        end
      end
      if (cyc == 3) begin
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
          $display("FAIL stall_ready_full got %b exp 0", bus.in_ready); n_fail++;
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (out_idx >= 6) begin
          $display("FAIL stream_extra got %h exp none", got); n_fail++;
        end else if (got !== st_exp[out_idx]) begin
          $display("FAIL stream_out%0d got %h exp %h", out_idx, got, st_exp[out_idx]); n_fail++;
        end
        out_idx++;
      end
      holding = bus.out_valid && !bus.out_ready;
      held    = got;
      acc_in  = bus.in_valid && bus.in_ready;
      step();
      if (acc_in) in_idx++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n_checks++;
    if (in_idx != 6 || out_idx != 6) begin
      $display("FAIL stream_count got in=%0d out=%0d exp in=6 out=6", in_idx, out_idx); n_fail++;
    end
  endtask

  task automatic test_reset_midflight();
    bus.out_ready = 1'b0;
    send_pair(8'sd0, 8'sd0, -8'sd128, 8'sd0, 2'd2);
    send_pair(8'sd1, 8'sd1, 8'sd1, 8'sd1, 2'd0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.ovf !== 1'b1) begin
      $display("FAIL flight_pre got v=%b ovf=%b exp v=1 ovf=1", bus.out_valid, bus.ovf); n_fail++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || outs() !== 32'h0 || bus.ovf !== 1'b0 || bus.in_ready !== 1'b1) begin
      $display("FAIL flight_reset got v=%b %h ovf=%b rdy=%b exp v=0 00000000 ovf=0 rdy=1",
               bus.out_valid, outs(), bus.ovf, bus.in_ready); n_fail++;
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
        $display("FAIL flight_ghost cyc %0d got %b exp 0", i, bus.out_valid); n_fail++;
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_1_r    = 8'sd0;
    bus.in_1_i    = 8'sd0;
    bus.in_2_r    = 8'sd0;
    bus.in_2_i    = 8'sd0;
    bus.tw_sel    = 2'd0;
    bus.out_ready = 1'b1;
    bus.ovf_clr   = 1'b0;
    #1;
    test_reset();
    test_twiddle0();
    test_twiddle2();
    test_twiddle13();
    test_overflow();
    test_back_to_back_stall();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end
endmodule
